// File: rtl/frame_source_arbiter.sv
// Round-robin frame arbiter sharing one pixel processor between two camera sources.
// Forwards the granted source's pixels, tags the processor result, and converts stalls into stop commands.
module frame_source_arbiter #(
    parameter int unsigned FRAME_PIXELS   = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] src_req,
    output logic [1:0] src_grant,
    input  logic [1:0] src_pixel_valid,
    input  logic [7:0] src0_pixel_data,
    input  logic [7:0] src1_pixel_data,
    output logic       proc_pixel_valid,
    output logic [7:0] proc_pixel_data,
    input  logic       proc_busy,
    input  logic       proc_command_valid,
    input  logic [2:0] proc_motor_command,
    output logic       cmd_valid,
    output logic       cmd_src,
    output logic [2:0] cmd_motor,
    output logic       timeout_pulse,
    output logic [1:0] arb_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t             state, state_d;
    logic               gsel, gsel_d;
    logic               last_served, last_served_d;
    logic [CNT_W-1:0]   pix_cnt, pix_cnt_d;
    logic [CNT_W-1:0]   wd_cnt, wd_cnt_d;
    logic [1:0]         grant_d;
    logic               ppv_d;
    logic [7:0]         ppd_d;
    logic               cv_d;
    logic               cs_d;
    logic [2:0]         cm_d;
    logic               tp_d;

    logic               accept_c;
    logic               frame_done_c;
    logic               wd_limit_c;
    logic               winner_c;
    logic               start_c;
    logic [7:0]         sel_data_c;

    // A tie goes to the source that was not served last.
    assign winner_c     = src_req[1] & (~src_req[0] | ~last_served);
    assign start_c      = (state == IDLE) && !proc_busy && (src_req != 2'b00);
    assign accept_c     = (state == STREAM) && src_pixel_valid[gsel];
    assign frame_done_c = accept_c && (pix_cnt == CNT_W'(FRAME_PIXELS - 1));
    assign wd_limit_c   = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign sel_data_c   = gsel ? src1_pixel_data : src0_pixel_data;
    assign arb_state    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:   if (start_c) state_d = STREAM;
            STREAM: begin
                if (frame_done_c)               state_d = WAIT;
                else if (!accept_c && wd_limit_c) state_d = DRAIN;
            end
            WAIT:   if (proc_command_valid || wd_limit_c) state_d = DRAIN;
            DRAIN:  if (!proc_busy) state_d = IDLE;
        endcase
    end

    always_comb begin
        gsel_d        = gsel;
        last_served_d = last_served;
        pix_cnt_d     = pix_cnt;
        wd_cnt_d      = wd_cnt;
        grant_d       = src_grant;
        ppv_d         = 1'b0;
        ppd_d         = proc_pixel_data;
        cv_d          = 1'b0;
        cs_d          = cmd_src;
        cm_d          = cmd_motor;
        tp_d          = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_c) begin
                    gsel_d    = winner_c;
                    grant_d   = winner_c ? 2'b10 : 2'b01;
                    pix_cnt_d = '0;
                    wd_cnt_d  = '0;
                end
            end
            STREAM: begin
                if (accept_c) begin
                    ppv_d     = 1'b1;
                    ppd_d     = sel_data_c;
                    pix_cnt_d = pix_cnt + CNT_W'(1);
                    wd_cnt_d  = '0;
                    if (frame_done_c) grant_d = 2'b00;
                end else if (wd_limit_c) begin
                    cv_d    = 1'b1;
                    cs_d    = gsel;
                    cm_d    = 3'b000;
                    tp_d    = 1'b1;
                    grant_d = 2'b00;
                end else begin
                    wd_cnt_d = wd_cnt + CNT_W'(1);
                end
            end
            WAIT: begin
                // A real result on the limit cycle takes priority over the timeout.
                if (proc_command_valid) begin
                    cv_d = 1'b1;
                    cs_d = gsel;
                    cm_d = proc_motor_command;
                end else if (wd_limit_c) begin
                    cv_d = 1'b1;
                    cs_d = gsel;
                    cm_d = 3'b000;
                    tp_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (!proc_busy) last_served_d = gsel;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gsel             <= 1'b0;
            last_served      <= 1'b1;
            pix_cnt          <= '0;
            wd_cnt           <= '0;
            src_grant        <= 2'b00;
            proc_pixel_valid <= 1'b0;
            proc_pixel_data  <= 8'h00;
            cmd_valid        <= 1'b0;
            cmd_src          <= 1'b0;
            cmd_motor        <= 3'b000;
            timeout_pulse    <= 1'b0;
        end else begin
            gsel             <= gsel_d;
            last_served      <= last_served_d;
            pix_cnt          <= pix_cnt_d;
            wd_cnt           <= wd_cnt_d;
            src_grant        <= grant_d;
            proc_pixel_valid <= ppv_d;
            proc_pixel_data  <= ppd_d;
            cmd_valid        <= cv_d;
            cmd_src          <= cs_d;
            cmd_motor        <= cm_d;
            timeout_pulse    <= tp_d;
        end
    end

endmodule

// File: doc/frame_source_arbiter.md
# frame_source_arbiter

Shares the single image-processing pipeline (pixel in, motor command out) between two camera pixel sources. The block grants whole frames to one source at a time using round-robin and forwards that source's pixels to the processor. It captures the resulting motor command, tags it with the source index, and releases the processor before the next grant. A watchdog converts stalled streams or missing results into a tagged stop command so that neither source can lock the pipeline.

## Interface
- FRAME_PIXELS, 1024: pixels per frame; the grant ends after this many accepted pixels.
- TIMEOUT_CYCLES, 4096: watchdog limit for the STREAM and WAIT states.
- CNT_W, 16: width of the pixel and watchdog counters; must hold FRAME_PIXELS and TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_req  in  2  per-source frame request; level signal, sampled only in IDLE.
- src_grant  out  2  one-hot grant; source may stream while its bit is high.
- src_pixel_valid  in  2  per-source pixel strobe.
- src0_pixel_data  in  8  source 0 pixel.
- src1_pixel_data  in  8  source 1 pixel.
- proc_pixel_valid  out  1  pixel strobe to the processor.
- proc_pixel_data  out  8  pixel to the processor.
- proc_busy  in  1  processor is mid-frame.
- proc_command_valid  in  1  processor result strobe.
- proc_motor_command  in  3  processor result.
- cmd_valid  out  1  one-cycle tagged command strobe.
- cmd_src  out  1  source index of the command.
- cmd_motor  out  3  motor command; 3'b000 means timeout stop.
- timeout_pulse  out  1  one cycle, coincident with a timeout-generated cmd_valid.
- arb_state  out  2  IDLE=0, STREAM=1, WAIT=2, DRAIN=3.

## Operation
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - last_served resets to 1, so source 0 wins the first tie.
  - Pixel and watchdog counters reset to 0.
- IDLE:
  - Grants only when proc_busy==0 and src_req!=0.
  - Selection: if only one source requests, that source wins. If both request, the winner g is !last_served.
  - On a grant: src_grant[g] is set, pix_cnt=0, wd_cnt=0, and the state moves to STREAM.
- STREAM:
  - A pixel is accepted when src_pixel_valid[g]=1. The accepted pixel and data are registered onto proc_pixel_valid/proc_pixel_data.
  - pix_cnt increments on each accepted pixel.
  - The non-granted source's valid and data are ignored and dropped.
  - src_req changes have no effect once a grant is issued.
  - When the FRAME_PIXELS-th pixel is accepted, src_grant clears, wd_cnt=0, and the state moves to WAIT.
  - wd_cnt clears on each accepted pixel and increments otherwise. At wd_cnt==TIMEOUT_CYCLES-1 with no pixel accepted, the watchdog fires.
- WAIT:
  - wd_cnt increments every cycle.
  - On proc_command_valid: the command is emitted with cmd_src=g and cmd_motor=proc_motor_command, and the state moves to DRAIN.
  - If proc_command_valid arrives in the same cycle the watchdog limit is reached, the real command wins and no timeout is raised.
- Watchdog fire (STREAM or WAIT):
  - Emits cmd_valid with cmd_src=g, cmd_motor=3'b000, and timeout_pulse=1.
  - Clears src_grant and moves to DRAIN.
- DRAIN: waits for proc_busy==0, then sets last_served=g and returns to IDLE.
- proc_command_valid in IDLE, STREAM or DRAIN is ignored; no cmd_valid is produced.
- Output behaviour:
  - cmd_src and cmd_motor hold their last values between strobes.
  - proc_pixel_data holds its value when proc_pixel_valid=0.
- An asynchronous reset mid-frame returns the block to IDLE immediately. The processor must be reset by the same rst_n.

## Timing
- Request to grant:
  - src_req sampled in IDLE at edge N gives src_grant high after edge N, with arb_state=1 in the same cycle.
  - Pixels presented in the first granted cycle are accepted.
- Pixel path: one cycle of latency, from src_pixel_valid at edge N to proc_pixel_valid high after edge N.
- End of frame: src_grant falls after the edge that accepts the final pixel. That last pixel appears on proc_pixel_valid in the same cycle.
- Command path: proc_command_valid at edge N gives cmd_valid for exactly one cycle after edge N.
- Timeout: cmd_valid and timeout_pulse rise together one cycle after the limit edge.
- Back-to-back frames:
  - After the DRAIN exit edge, IDLE lasts at least one cycle, and the next grant follows that cycle at the earliest.
  - Minimum gap between two grants is therefore DRAIN + 1 IDLE cycle.
- src_grant is never two-hot. No grant is issued while proc_busy=1.

## Test plan
- Single frame from source 0:
  - Stimulus: src_req=01, 1024 consecutive pixels, processor returns 3'b010.
  - Required response: src_grant=01 for exactly 1024 accepted pixels; proc_pixel_valid count is 1024; cmd_valid with cmd_src=0 and cmd_motor=3'b010; back to IDLE.
- Contention:
  - Stimulus: src_req=11 held for 4 frames.
  - Required response: grants alternate 0,1,0,1; cmd_src sequence is 0,1,0,1.
- Interleaved traffic:
  - Stimulus: source 1 toggles valid while source 0 is granted, using data 0xAA versus 0x55.
  - Required response: only 0x55 reaches proc_pixel_data; the count stays 1024.
- Stream stall:
  - Stimulus: source stops after 500 pixels (TIMEOUT_CYCLES=64).
  - Required response: after 64 idle cycles, cmd_valid=1, timeout_pulse=1, cmd_motor=000; grant drops; DRAIN is entered.
- Missing result:
  - Stimulus: processor never asserts proc_command_valid.
  - Required response: timeout stop command 64 cycles after WAIT entry.
  - Boundary: command on the limit cycle yields the real command and timeout_pulse=0.
- Reset during STREAM at pixel 300:
  - Required response: all outputs are 0 immediately and arb_state=0.
  - Next request is granted to source 0 on a tie.
